// File: rtl/ram_word_streamer.sv
// rtl/ram_word_streamer.sv - command-driven word/slice streamer for a registered-read single-port RAM

module ram_word_streamer #(
    parameter int AW = 6,
    parameter int DW = 256,
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [SW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [SW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          ram_wr,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int NSL = DW / SW;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        STREAM,
        WR_COLLECT,
        WR_COMMIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] word;
    logic [DW-1:0] word_shift;

    // Read word drains LSB slice first, so the next slice is always the low bits after one shift.
    assign word_shift = word >> SW;

    // Single FSM; every output is a register updated on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            word      <= '0;
            cmd_ready <= 1'b1;
            s_ready   <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_wr    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_wr) begin
                            s_ready <= 1'b1;
                            state   <= WR_COLLECT;
                        end else begin
                            ram_rd   <= 1'b1;
                            ram_addr <= cmd_addr;
                            state    <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    ram_rd <= 1'b0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    word    <= ram_rdata;
                    m_data  <= ram_rdata[SW-1:0];
                    m_valid <= 1'b1;
                    m_last  <= (LAST == '0);
                    state   <= STREAM;
                end
                STREAM: begin
                    if (m_valid && m_ready) begin
                        if (cnt == LAST) begin
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            word   <= word_shift;
                            m_data <= word_shift[SW-1:0];
                            m_last <= (cnt == LAST - 1'b1);
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                WR_COLLECT: begin
                    if (s_valid && s_ready) begin
                        ram_wdata[int'(cnt)*SW +: SW] <= s_data;
                        if (cnt == LAST) begin
                            s_ready  <= 1'b0;
                            ram_wr   <= 1'b1;
                            ram_addr <= addr_q;
                            state    <= WR_COMMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WR_COMMIT: begin
                    ram_wr    <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    s_ready   <= 1'b0;
                    m_valid   <= 1'b0;
                    m_last    <= 1'b0;
                    ram_wr    <= 1'b0;
                    ram_rd    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_word_streamer.sv
// tb/tb_ram_word_streamer.sv - randomized self-checking bench for ram_word_streamer

module tb_ram_word_streamer;

    localparam int AW  = 6;
    localparam int DW  = 256;
    localparam int SW  = 32;
    localparam int NSL = DW / SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [SW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [SW-1:0] m_data;
    logic          m_valid, m_ready, m_last;
    logic          busy, done;
    logic          ram_wr, ram_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_word_streamer #(.AW(AW), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done),
        .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Reference contents: what the RAM must hold given only the writes that fully committed.
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] mem     [64];

    int            n_wr = 0, n_rd = 0, n_both = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    // Registered-read RAM model; contents reload from the committed image while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            if (ram_rd) ram_rdata <= mem[ram_addr];
        end
    end

    // Strobe monitor.
    always @(posedge clk) begin
        if (ram_wr) begin
            n_wr++;
            last_wr_addr = ram_addr;
            last_wr_data = ram_wdata;
        end
        if (ram_rd) n_rd++;
        if (ram_wr && ram_rd) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int j = 0; j < NSL; j++) w[j*SW +: SW] = $urandom;
        return w;
    endfunction

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Entered one cycle after acceptance; walks the read timeline and the whole stream.
    task automatic read_after_accept(input logic [AW-1:0] a, input int mode, output logic [DW-1:0] got);
        int            k, n;
        logic          rdy;
        logic [SW-1:0] expd;
        got = '0;
        total++;
        if (ram_rd !== 1'b1 || ram_addr !== a) begin
            bad++;
            $display("FAIL rd_strobe: ram_rd=%0b ram_addr=%0d required 1/%0d", ram_rd, ram_addr, a);
        end
        tick();
        total++;
        if (ram_rd !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_wait: ram_rd=%0b m_valid=%0b required 0/0", ram_rd, m_valid);
        end
        tick();
        total++;
        if (m_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_valid: m_valid=%0b required 1 at T+3", m_valid);
        end
        k = 0;
        n = 0;
        s_valid = 1'b1;
        s_data  = $urandom;
        while (k < NSL && n < 200) begin
            expd = ref_mem[a][k*SW +: SW];
            total++;
            if (m_valid !== 1'b1 || m_data !== expd || m_last !== (k == NSL-1) || s_ready !== 1'b0) begin
                bad++;
                $display("FAIL stream_slice%0d: valid=%0b data=%h last=%0b s_ready=%0b required 1/%h/%0b/0",
                         k, m_valid, m_data, m_last, s_ready, expd, (k == NSL-1));
            end
            got[k*SW +: SW] = m_data;
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
            m_ready = rdy;
            tick();
            n++;
            if (rdy) k++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        total++;
        if (k != NSL) begin
            bad++;
            $display("FAIL stream_count: slices=%0d required %0d", k, NSL);
        end
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_done: done=%0b cmd_ready=%0b busy=%0b m_valid=%0b required 1/1/0/0",
                     done, cmd_ready, busy, m_valid);
        end
    endtask

    task automatic write_collect(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int nsl, input bit gaps);
        int   k, n;
        logic v, sr;
        send_cmd(1'b1, a);
        k = 0;
        n = 0;
        while (k < nsl && n < 200) begin
            v  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = v ? d[k*SW +: SW] : SW'($urandom);
            sr = s_ready;
            tick();
            n++;
            if (v && sr) k++;
        end
        s_valid = 1'b0;
        total++;
        if (k != nsl) begin
            bad++;
            $display("FAIL wr_collect: slices=%0d required %0d", k, nsl);
        end
    endtask

    task automatic write_full(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit gaps);
        int w0;
        w0 = n_wr;
        write_collect(a, d, NSL, gaps);
        total++;
        if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== a || ram_wdata !== d) begin
            bad++;
            $display("FAIL wr_commit: ram_wr=%0b ram_rd=%0b addr=%0d wdata=%h required 1/0/%0d/%h",
                     ram_wr, ram_rd, ram_addr, ram_wdata, a, d);
        end
        ref_mem[a] = d;
        tick();
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || ram_wr !== 1'b0 || n_wr != w0 + 1) begin
            bad++;
            $display("FAIL wr_done: done=%0b cmd_ready=%0b busy=%0b ram_wr=%0b writes=%0d required 1/1/0/0/%0d",
                     done, cmd_ready, busy, ram_wr, n_wr - w0, 1);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL wr_done_pulse: done=%0b required 0", done);
        end
    endtask

    task automatic read_full(input logic [AW-1:0] a, input int mode);
        int            r0;
        logic [DW-1:0] got;
        send_cmd(1'b0, a);
        r0 = n_rd;
        read_after_accept(a, mode, got);
        tick();
        total++;
        if (done !== 1'b0 || n_rd != r0 + 1) begin
            bad++;
            $display("FAIL rd_once: done=%0b reads=%0d required 0/1", done, n_rd - r0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 ||
            s_ready !== 1'b0 || ram_wr !== 1'b0 || ram_rd !== 1'b0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cmd_ready=%0b busy=%0b done=%0b m_valid=%0b s_ready=%0b wr=%0b rd=%0b required 1/0/0/0/0/0/0",
                     cmd_ready, busy, done, m_valid, s_ready, ram_wr, ram_rd);
        end
    endtask

    task automatic test_write();
        logic [DW-1:0] d;
        for (int i = 0; i < NSL; i++) d[i*SW +: SW] = SW'(32'h11111111 * (i + 1));
        write_full(6'd5, d, 1'b1);
        total++;
        if (last_wr_addr !== 6'd5 || last_wr_data !== d) begin
            bad++;
            $display("FAIL wr_addr5: addr=%0d data=%h required 5/%h", last_wr_addr, last_wr_data, d);
        end
    endtask

    task automatic test_read();
        read_full(6'd5, 0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) read_full(AW'($urandom_range(0, 63)), 1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d, got;
        d = rand_word();
        write_collect(6'd63, d, NSL, 1'b0);
        ref_mem[63] = d;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 6'd63;
        tick();
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_cycle: done=%0b cmd_ready=%0b required 1/1", done, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        read_after_accept(6'd63, 1, got);
        total++;
        if (got !== d) begin
            bad++;
            $display("FAIL b2b_data: read=%h required %h", got, d);
        end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        send_cmd(1'b0, 6'd9);
        tick();
        tick();
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (m_valid !== 1'b0 || ram_rd !== 1'b0 || ram_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_stream: m_valid=%0b rd=%0b wr=%0b busy=%0b done=%0b required all 0",
                     m_valid, ram_rd, ram_wr, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_release: cmd_ready=%0b done=%0b m_valid=%0b required 1/0/0", cmd_ready, done, m_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        int            w0;
        logic [AW-1:0] a;
        a  = AW'($urandom_range(10, 40));
        w0 = n_wr;
        write_collect(a, rand_word(), 3, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL rst_write: busy=%0b s_ready=%0b ram_wr=%0b required 0/0/0", busy, s_ready, ram_wr);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (n_wr != w0) begin
            bad++;
            $display("FAIL rst_no_commit: writes=%0d required 0", n_wr - w0);
        end
        read_full(a, 0);
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) write_full(AW'($urandom_range(0, 63)), rand_word(), 1'b1);
            else read_full(AW'($urandom_range(0, 63)), int'($urandom_range(0, 1)));
        end
        total++;
        if (n_both != 0) begin
            bad++;
            $display("FAIL strobe_overlap: cycles=%0d required 0", n_both);
        end
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = rand_word();
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_back_to_back();
        test_reset_mid_stream();
        test_reset_mid_write();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
